// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider with its start/abort sequencing FSM; result registered on entry to DONE.
// Optional feature: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    div_start_i,
  input  logic                    div_signed_i,
  input  logic [DATA_WIDTH-1:0]   div_data1_i,
  input  logic [DATA_WIDTH-1:0]   div_data2_i,
  output logic [2*DATA_WIDTH-1:0] div_result_o,
  output logic                    div_done_o,
  output logic                    div_busy_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   rem_q, quo_q, dvsr_q;
  logic                    sign_q_q, sign_r_q;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [2*DATA_WIDTH-1:0] result_q;

  logic                    s1, s2, take, div_zero, early;
  logic [DATA_WIDTH-1:0]   a_mag, b_mag;
  logic [DATA_WIDTH:0]     shifted, diff;
  logic                    ge;
  logic [DATA_WIDTH-1:0]   rem_nxt, quo_nxt, rem_fin, quo_fin;

  assign s1       = div_signed_i & div_data1_i[DATA_WIDTH-1];
  assign s2       = div_signed_i & div_data2_i[DATA_WIDTH-1];
  assign a_mag    = s1 ? -div_data1_i : div_data1_i;
  assign b_mag    = s2 ? -div_data2_i : div_data2_i;
  assign take     = div_start_i & ~flush_i;
  assign div_zero = (div_data2_i == '0);

`ifdef DIV_EARLY_OUT_EN
  assign early = (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  assign shifted = {rem_q, quo_q[DATA_WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dvsr_q});
  assign diff    = shifted - {1'b0, dvsr_q};
  assign rem_nxt = ge ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  assign quo_nxt = {quo_q[DATA_WIDTH-2:0], ge};
  assign quo_fin = sign_q_q ? -quo_nxt : quo_nxt;
  assign rem_fin = sign_r_q ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (take) state_nxt = (div_zero || early) ? DONE : CALC;
      CALC: begin
        if (flush_i || !div_start_i)                   state_nxt = IDLE;
        else if (cnt == CNT_WIDTH'(DATA_WIDTH - 1))    state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          if (div_zero) begin
            result_q <= {div_data1_i, {DATA_WIDTH{1'b1}}};
          end else if (early) begin
            result_q <= {div_data1_i, {DATA_WIDTH{1'b0}}};
          end else begin
            rem_q    <= '0;
            quo_q    <= a_mag;
            dvsr_q   <= b_mag;
            sign_q_q <= s1 ^ s2;
            sign_r_q <= s1;
            cnt      <= '0;
          end
        end
        CALC: if (!flush_i && div_start_i) begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + 1'b1;
          // Sign fix-up folds into the final iteration so the result is ready in DONE.
          if (state_nxt == DONE) result_q <= {rem_fin, quo_fin};
        end
        default: ;
      endcase
    end
  end

  assign div_result_o = result_q;
  assign div_done_o   = (state == DONE);
  assign div_busy_o   = (state == CALC);

endmodule
